video_pixel_pipe: RTL and testbench
===================================

Name: video_pixel_pipe

Overview:
- Streaming, parametrised successor to the single-cycle image_processor.
- Accepts one RGB pixel per cycle on a valid/ready stream and computes luma through a 2-stage pipeline.
- Selects a per-frame output mode (gray / negative / binary / raw red) and tags each output pixel with frame and line markers from internal raster counters.
- Sits between the pixel source (frame reader / DMA) and the output writer; tolerates downstream backpressure.

Parameters:
- DATA_W, 8, bits per colour channel and per output pixel.
- FRAME_WIDTH, 128, pixels per line.
- FRAME_HEIGHT, 128, lines per frame.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  input pixel valid
- s_ready  output  1  block can accept input pixel
- s_r  input  DATA_W  red channel
- s_g  input  DATA_W  green channel
- s_b  input  DATA_W  blue channel
- mode  input  2  0=gray, 1=negative, 2=binary, 3=raw red; sampled at frame start
- threshold_val  input  DATA_W  binary threshold; sampled at frame start
- m_valid  output  1  output pixel valid
- m_ready  input  1  downstream accepts output pixel
- m_data  output  DATA_W  processed pixel
- m_bin  output  1  gray >= threshold, independent of mode
- m_sof  output  1  output pixel is x=0, y=0
- m_eol  output  1  output pixel is x=FRAME_WIDTH-1
- m_eof  output  1  output pixel is last pixel of frame
- frame_count  output  FCNT_W  completed frames, wraps at 2^FCNT_W
- stat_min  output  DATA_W  min gray of last frame (STATS_EN)
- stat_max  output  DATA_W  max gray of last frame (STATS_EN)
- stat_valid  output  1  1-cycle pulse, stats updated (STATS_EN)

Behaviour:
- Reset values: s_ready=1 after reset deasserts; m_valid, m_data, m_bin, m_sof, m_eol, m_eof, frame_count, stat_min, stat_max and stat_valid all 0.
  - Internal x/y counters reset to 0; stage valids cleared.
  - Reset mid-frame discards in-flight pixels; the next accepted pixel is x=0, y=0.
- Pipeline enable: en = !m_valid || m_ready; s_ready = en.
  - All stages shift together when en=1 and hold all data and sideband when en=0.
  - Bubbles are not collapsed.
- Latency: 2 cycles from input accept (s_valid && s_ready) to m_valid with no stall.
- Stage 1: sum = 77*R + 150*G + 29*B, computed at DATA_W+8 bits unsigned.
  - gray = sum >> 8, truncated to DATA_W; the result never exceeds 2^DATA_W-1.
  - R is carried forward for mode 3.
- Stage 2:
  - neg = (2^DATA_W-1) - gray.
  - bin = (gray >= threshold).
  - m_data by mode: 0 gray; 1 neg; 2 all-ones if bin else 0; 3 R.
  - m_bin = bin.
- Raster counters:
  - Advance on each input accept: x increments; at FRAME_WIDTH-1, x wraps to 0 and y increments; at the last pixel, y wraps to 0.
  - sof/eol/eof are generated at accept and travel with the pixel.
- Frame parameters: on accept of the pixel with x=0, y=0, mode and threshold_val are latched and held for the whole frame. Changes mid-frame take effect at the next frame start.
- frame_count increments by 1 in the cycle an m_eof pixel handshakes (m_valid && m_ready), and wraps to 0.
- Simultaneous input accept and output handshake in the same cycle: both complete; throughput is 1 pixel/cycle.

Optional Feature:
- Macro: VIDEO_PIXEL_PIPE_STATS_EN.
- Defined:
  - Per-frame min/max of stage-2 gray is tracked on each output handshake. Accumulators reload from the sof pixel.
  - On the eof handshake, stat_min/stat_max are updated to include that pixel, and stat_valid pulses for 1 cycle.
  - Values hold until the next eof.
- Undefined: stat_min, stat_max and stat_valid are tied to 0 and no tracking logic is built.

Test Plan:
- R=G=B=100, mode=0, m_ready=1 -> m_data=100 two cycles after accept; m_bin=1 with threshold 100.
- R=255, G=0, B=0; modes 0/1/2/3 with threshold 100 over four frames -> m_data = 76 / 179 / 0 / 255; m_bin=0.
- Continuous input, m_ready held low for 3 cycles mid-stream -> s_ready=0 and m_data/m_valid held stable; no pixel lost or duplicated; order preserved.
- FRAME_WIDTH=4, FRAME_HEIGHT=2, 17 pixels streamed:
  - m_eol on pixels 4, 8, 12, 16; m_eof on 8 and 16; m_sof on 1, 9, 17.
  - frame_count is 2 after pixel 16.
  - mode changed 0->1 at pixel 3 -> pixels 3-8 still in mode 0; pixel 9 onward in mode 1.
- rst asserted for 1 cycle after pixel 5 of a 4x2 frame -> all outputs 0; the next accepted pixel is tagged m_sof.
- With STATS_EN, 4x2 frame of gray pixels 10, 20, ..., 80 (R=G=B) -> stat_min=10, stat_max=80, stat_valid pulses once after the eof handshake.

Source files
------------

// File: rtl/video_pixel_pipe.sv
// Streaming RGB-to-luma pixel pipe: 2-stage valid/ready pipeline with per-frame mode select and raster markers.
// Optional per-frame gray min/max statistics are built when VIDEO_PIXEL_PIPE_STATS_EN is defined.
module video_pixel_pipe #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FRAME_WIDTH  = 128,
    parameter int unsigned FRAME_HEIGHT = 128,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_r,
    input  logic [DATA_W-1:0] s_g,
    input  logic [DATA_W-1:0] s_b,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] threshold_val,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_bin,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [FCNT_W-1:0] frame_count,
    output logic [DATA_W-1:0] stat_min,
    output logic [DATA_W-1:0] stat_max,
    output logic              stat_valid
);

    localparam int unsigned SUM_W = DATA_W + 8;
    localparam int unsigned X_W   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned Y_W   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [X_W-1:0]    X_LAST  = X_W'(FRAME_WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(FRAME_HEIGHT - 1);
    localparam logic [DATA_W-1:0] PIX_MAX = {DATA_W{1'b1}};

    logic en;
    logic accept;
    logic out_hs;

    // One shared enable: every stage advances together or everything holds.
    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign out_hs  = m_valid && m_ready;

    // ---------------- raster position and frame parameters ----------------
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [1:0]        mode_lat;
    logic [DATA_W-1:0] thr_lat;
    logic              at_sof;
    logic              at_eol;
    logic              at_eof;
    logic [1:0]        mode_cur;
    logic [DATA_W-1:0] thr_cur;

    // The frame's first pixel uses the live mode/threshold; the rest use the latched copy.
    always_comb begin
        at_sof   = (x_cnt == '0) && (y_cnt == '0);
        at_eol   = (x_cnt == X_LAST);
        at_eof   = at_eol && (y_cnt == Y_LAST);
        mode_cur = at_sof ? mode : mode_lat;
        thr_cur  = at_sof ? threshold_val : thr_lat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            mode_lat <= '0;
            thr_lat  <= '0;
        end else if (accept) begin
            if (at_sof) begin
                mode_lat <= mode;
                thr_lat  <= threshold_val;
            end
            if (at_eol) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // ---------------- stage 1: luma ----------------
    logic [SUM_W-1:0]  sum_c;
    logic [DATA_W-1:0] gray_c;

    // Weights sum to 256, so the shifted result always fits in DATA_W bits.
    always_comb begin
        sum_c  = SUM_W'(77) * SUM_W'(s_r) + SUM_W'(150) * SUM_W'(s_g) + SUM_W'(29) * SUM_W'(s_b);
        gray_c = sum_c[SUM_W-1:8];
    end

    logic              v1;
    logic [DATA_W-1:0] gray1;
    logic [DATA_W-1:0] r1;
    logic              sof1;
    logic              eol1;
    logic              eof1;
    logic [1:0]        mode1;
    logic [DATA_W-1:0] thr1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            gray1 <= '0;
            r1    <= '0;
            sof1  <= 1'b0;
            eol1  <= 1'b0;
            eof1  <= 1'b0;
            mode1 <= '0;
            thr1  <= '0;
        end else if (en) begin
            v1    <= accept;
            gray1 <= gray_c;
            r1    <= s_r;
            sof1  <= at_sof;
            eol1  <= at_eol;
            eof1  <= at_eof;
            mode1 <= mode_cur;
            thr1  <= thr_cur;
        end
    end

    // ---------------- stage 2: mode select ----------------
    logic [DATA_W-1:0] neg_c;
    logic              bin_c;
    logic [DATA_W-1:0] data_c;

    always_comb begin
        neg_c  = PIX_MAX - gray1;
        bin_c  = (gray1 >= thr1);
        data_c = gray1;
        case (mode1)
            2'd0:    data_c = gray1;
            2'd1:    data_c = neg_c;
            2'd2:    data_c = bin_c ? PIX_MAX : '0;
            default: data_c = r1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_bin   <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (en) begin
            m_valid <= v1;
            m_data  <= data_c;
            m_bin   <= bin_c;
            m_sof   <= sof1;
            m_eol   <= eol1;
            m_eof   <= eof1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (out_hs && m_eof) begin
            frame_count <= frame_count + 1'b1;
        end
    end

`ifdef VIDEO_PIXEL_PIPE_STATS_EN
    // ---------------- per-frame gray statistics ----------------
    logic [DATA_W-1:0] gray2;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;
    logic [DATA_W-1:0] fmin_c;
    logic [DATA_W-1:0] fmax_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            gray2 <= '0;
        end else if (en) begin
            gray2 <= gray1;
        end
    end

    // Running min/max including the pixel currently handshaking; sof restarts the frame.
    always_comb begin
        fmin_c = gray2;
        fmax_c = gray2;
        if (!m_sof) begin
            fmin_c = (gray2 < acc_min) ? gray2 : acc_min;
            fmax_c = (gray2 > acc_max) ? gray2 : acc_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_min    <= '0;
            acc_max    <= '0;
            stat_min   <= '0;
            stat_max   <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (out_hs) begin
                acc_min <= fmin_c;
                acc_max <= fmax_c;
                if (m_eof) begin
                    stat_min   <= fmin_c;
                    stat_max   <= fmax_c;
                    stat_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign stat_min   = '0;
    assign stat_max   = '0;
    assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_pixel_pipe.sv
// Scoreboard bench for video_pixel_pipe on a 4x2 raster; stat checks follow VIDEO_PIXEL_PIPE_STATS_EN.
`timescale 1ns/1ps
module tb_video_pixel_pipe;

    localparam int unsigned DW  = 8;
    localparam int unsigned FW  = 4;
    localparam int unsigned FH  = 2;
    localparam int unsigned FCW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_r;
    logic [DW-1:0] s_g;
    logic [DW-1:0] s_b;
    logic [1:0]    mode;
    logic [DW-1:0] threshold_val;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_bin;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic [FCW-1:0] frame_count;
    logic [DW-1:0] stat_min;
    logic [DW-1:0] stat_max;
    logic          stat_valid;

    always #5 clk = ~clk;

    video_pixel_pipe #(
        .DATA_W(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .FCNT_W(FCW)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b), .mode(mode), .threshold_val(threshold_val),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bin(m_bin),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .frame_count(frame_count),
        .stat_min(stat_min), .stat_max(stat_max), .stat_valid(stat_valid)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          bin;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    pix_t sb[$];
    int checks = 0;
    int errors = 0;
    int mx = 0;
    int my = 0;
    logic [1:0]    fmode = 2'd0;
    logic [DW-1:0] fthr  = '0;

    function automatic pix_t model(input logic [DW-1:0] r, g, b,
                                   input logic [1:0] md, input logic [DW-1:0] th);
        int sum;
        logic [DW-1:0] gray;
        pix_t p;
        sum  = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        gray = DW'(sum >> 8);
        p    = '0;
        p.bin = (gray >= th);
        case (md)
            2'd0:    p.data = gray;
            2'd1:    p.data = {DW{1'b1}} - gray;
            2'd2:    p.data = p.bin ? {DW{1'b1}} : '0;
            default: p.data = r;
        endcase
        return p;
    endfunction

    // Drive one cycle, sample at the falling edge, and push the model result for an accepted pixel.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] r, g, b,
                               input logic [1:0] md, input logic [DW-1:0] th, input logic rdy,
                               output logic acc, output logic hs, output pix_t got);
        pix_t e;
        @(posedge clk); #1;
        s_valid = v; s_r = r; s_g = g; s_b = b;
        mode = md; threshold_val = th; m_ready = rdy;
        @(negedge clk);
        acc = s_valid && s_ready;
        hs  = m_valid && m_ready;
        got = {m_data, m_bin, m_sof, m_eol, m_eof};
        if (acc) begin
            if (mx == 0 && my == 0) begin
                fmode = md;
                fthr  = th;
            end
            e     = model(r, g, b, fmode, fthr);
            e.sof = (mx == 0 && my == 0);
            e.eol = (mx == int'(FW) - 1);
            e.eof = e.eol && (my == int'(FH) - 1);
            sb.push_back(e);
            if (mx == int'(FW) - 1) begin
                mx = 0;
                my = (my == int'(FH) - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        mx = 0; my = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready);
        end
        checks++;
        if ({m_valid, m_data, m_bin, m_sof, m_eol, m_eof, frame_count, stat_min, stat_max, stat_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%0d bin=%b sof=%b eol=%b eof=%b fc=%0d smin=%0d smax=%0d sv=%b required all 0",
                     m_valid, m_data, m_bin, m_sof, m_eol, m_eof, frame_count, stat_min, stat_max, stat_valid);
        end
    endtask

    task automatic test_gray();
        logic acc, hs;
        pix_t got, want;
        int p = 0, cyc = 0, nout = 0, first_hs = -1;
        apply_reset();
        while (nout < 8 && cyc < 60) begin
            drive_cycle(p < 8, DW'(100), DW'(100), DW'(100), 2'd0, DW'(100), 1'b1, acc, hs, got);
            if (acc) p++;
            if (hs) begin
                if (first_hs < 0) first_hs = cyc;
                nout++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL gray_sb: got %h required no output", got);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        errors++; $display("FAIL gray_sb: got %h required %h", got, want);
                    end
                end
                checks++;
                if (got.data !== DW'(100) || got.bin !== 1'b1) begin
                    errors++; $display("FAIL gray_value: got data=%0d bin=%b required data=100 bin=1", got.data, got.bin);
                end
            end
            cyc++;
        end
        checks++;
        if (first_hs != 2) begin
            errors++; $display("FAIL gray_latency: got %0d cycles required 2", first_hs);
        end
        checks++;
        if (nout != 8) begin
            errors++; $display("FAIL gray_count: got %0d outputs required 8", nout);
        end
    endtask

    task automatic test_modes();
        logic acc, hs;
        pix_t got, want;
        logic [DW-1:0] lit [4];
        int p = 0, cyc = 0, nout = 0;
        lit[0] = DW'(76); lit[1] = DW'(179); lit[2] = DW'(0); lit[3] = DW'(255);
        while (nout < 32 && cyc < 120) begin
            drive_cycle(p < 32, DW'(255), DW'(0), DW'(0), 2'(p / 8), DW'(100), 1'b1, acc, hs, got);
            if (acc) p++;
            if (hs) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL modes_sb: got %h required no output", got);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        errors++; $display("FAIL modes_sb: got %h required %h", got, want);
                    end
                end
                checks++;
                if (got.data !== lit[nout / 8] || got.bin !== 1'b0) begin
                    errors++;
                    $display("FAIL modes_value: frame %0d got data=%0d bin=%b required data=%0d bin=0",
                             nout / 8, got.data, got.bin, lit[nout / 8]);
                end
                nout++;
            end
            cyc++;
        end
        drive_cycle(1'b0, '0, '0, '0, 2'd0, '0, 1'b1, acc, hs, got);
        checks++;
        if (nout != 32 || frame_count !== FCW'(5)) begin
            errors++; $display("FAIL modes_frames: got outputs=%0d fc=%0d required 32 and 5", nout, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, hs;
        pix_t got, want;
        logic [DW-1:0] held;
        logic [DW-1:0] v;
        int p = 0, cyc = 0, nout = 0;
        held = '0;
        while (nout < 16 && cyc < 80) begin
            v = DW'(p * 13 + 5);
            drive_cycle(p < 16, v, v, v, 2'd0, '0, !(cyc >= 6 && cyc < 9), acc, hs, got);
            if (acc) p++;
            if (cyc >= 6 && cyc < 9) begin
                checks++;
                if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_ready: cycle %0d got s_ready=%b m_valid=%b required 0 and 1", cyc, s_ready, m_valid);
                end
                if (cyc == 6) held = m_data;
                else begin
                    checks++;
                    if (m_data !== held) begin
                        errors++; $display("FAIL stall_hold: cycle %0d got %0d required %0d", cyc, m_data, held);
                    end
                end
            end
            if (hs) begin
                nout++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stall_sb: got %h required no output", got);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        errors++; $display("FAIL stall_sb: got %h required %h", got, want);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (nout != 16 || sb.size() != 0) begin
            errors++; $display("FAIL stall_count: got %0d outputs, %0d pending required 16 and 0", nout, sb.size());
        end
    endtask

    task automatic test_markers();
        logic acc, hs;
        pix_t got, want;
        int p = 0, cyc = 0, n = 0;
        logic [DW-1:0] d_exp;
        apply_reset();
        while (n < 17 && cyc < 80) begin
            drive_cycle(p < 17, DW'(50), DW'(50), DW'(50), (p >= 2) ? 2'd1 : 2'd0, DW'(100), 1'b1, acc, hs, got);
            if (acc) p++;
            if (hs) begin
                n++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL marker_sb: got %h required no output", got);
                end else begin
                    want = sb.pop_front();
                    if (got !== want) begin
                        errors++; $display("FAIL marker_sb: got %h required %h", got, want);
                    end
                end
                d_exp = (n <= 8) ? DW'(50) : DW'(205);
                checks++;
                if (got.sof !== (n == 1 || n == 9 || n == 17) || got.eol !== (n % 4 == 0) ||
                    got.eof !== (n == 8 || n == 16) || got.data !== d_exp) begin
                    errors++;
                    $display("FAIL marker_px%0d: got sof=%b eol=%b eof=%b data=%0d required data=%0d",
                             n, got.sof, got.eol, got.eof, got.data, d_exp);
                end
                if (n == 17) begin
                    checks++;
                    if (frame_count !== FCW'(2)) begin
                        errors++; $display("FAIL marker_fc: got %0d required 2", frame_count);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (n != 17) begin
            errors++; $display("FAIL marker_count: got %0d outputs required 17", n);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, hs;
        pix_t got, want;
        int p = 0, n = 0, cyc = 0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, DW'(c * 20), DW'(c * 20), DW'(c * 20), 2'd0, '0, 1'b1, acc, hs, got);
            if (hs) begin
                checks++;
                want = sb.pop_front();
                if (got !== want) begin
                    errors++; $display("FAIL rstmid_pre: got %h required %h", got, want);
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        mx = 0; my = 0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_bin, m_sof, m_eol, m_eof, frame_count} !== '0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs: got v=%b d=%0d sof=%b eol=%b eof=%b fc=%0d rdy=%b required zeros and ready",
                     m_valid, m_data, m_sof, m_eol, m_eof, frame_count, s_ready);
        end
        while (n < 1 && cyc < 20) begin
            drive_cycle(p < 1, DW'(33), DW'(33), DW'(33), 2'd0, '0, 1'b1, acc, hs, got);
            if (acc) p++;
            if (hs) begin
                n++;
                checks++;
                want = (sb.size() > 0) ? sb.pop_front() : '0;
                if (got !== want || got.sof !== 1'b1) begin
                    errors++; $display("FAIL rstmid_sof: got %h required %h with sof", got, want);
                end
            end
            cyc++;
        end
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL rstmid_count: got %0d outputs required 1", n);
        end
    endtask

    task automatic test_stats();
        logic acc, hs;
        pix_t got, want;
        int p = 0, n = 0, cyc = 0, pulses = 0;
        logic [DW-1:0] v;
        logic [DW-1:0] min_exp, max_exp;
        int pulses_exp;
`ifdef VIDEO_PIXEL_PIPE_STATS_EN
        min_exp = DW'(10); max_exp = DW'(80); pulses_exp = 1;
`else
        min_exp = '0; max_exp = '0; pulses_exp = 0;
`endif
        apply_reset();
        while (n < 8 && cyc < 60) begin
            v = DW'((p + 1) * 10);
            drive_cycle(p < 8, v, v, v, 2'd0, '0, 1'b1, acc, hs, got);
            if (acc) p++;
            if (stat_valid === 1'b1) pulses++;
            if (hs) begin
                n++;
                checks++;
                want = (sb.size() > 0) ? sb.pop_front() : '0;
                if (got !== want) begin
                    errors++; $display("FAIL stats_sb: got %h required %h", got, want);
                end
            end
            cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, '0, '0, '0, 2'd0, '0, 1'b1, acc, hs, got);
            if (stat_valid === 1'b1) pulses++;
        end
        checks++;
        if (stat_min !== min_exp || stat_max !== max_exp) begin
            errors++; $display("FAIL stats_minmax: got %0d/%0d required %0d/%0d", stat_min, stat_max, min_exp, max_exp);
        end
        checks++;
        if (pulses != pulses_exp || n != 8) begin
            errors++; $display("FAIL stats_pulse: got %0d pulses, %0d outputs required %0d and 8", pulses, n, pulses_exp);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_r = '0; s_g = '0; s_b = '0;
        mode = 2'd0; threshold_val = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_gray();
        test_modes();
        test_back_to_back();
        test_markers();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
